uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART program loader: receives a framed image (0xA5, count16, little-endian words) and writes it to
// instruction memory while holding the core in reset. Define UART_BOOT_LOADER_ECHO_EN to echo bytes on TX.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_hold,
  output logic        o_load_done,
  output logic        o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_CNT0, P_CNT1, P_DATA, P_DONE} p_state_t;

  rx_state_t     r_rxState;
  logic          r_rxMeta, r_rxSync, r_rxPrev;
  logic [CW-1:0] r_rxCnt;
  logic [2:0]    r_rxBit;
  logic [7:0]    r_rxShift, r_rxByte;
  logic          r_byteValid, r_rxErr;

  p_state_t      r_pState;
  logic [7:0]    r_cntLo;
  logic [15:0]   r_count, r_index;
  logic [1:0]    r_lane;
  logic [23:0]   r_word;
  logic [15:0]   w_count;

  assign w_count = {r_rxByte, r_cntLo};

  // Receiver: counters sample every bit at its midpoint, measured from the synchronized falling edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rxMeta    <= 1'b1;
      r_rxSync    <= 1'b1;
      r_rxPrev    <= 1'b1;
      r_rxState   <= RX_IDLE;
      r_rxCnt     <= '0;
      r_rxBit     <= '0;
      r_rxShift   <= '0;
      r_rxByte    <= '0;
      r_byteValid <= 1'b0;
      r_rxErr     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_rxMeta    <= i_uart_rx;
      r_rxSync    <= r_rxMeta;
      r_rxPrev    <= r_rxSync;
      r_byteValid <= 1'b0;
      r_rxErr     <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          if (r_rxPrev && !r_rxSync) begin
            r_rxState <= RX_START;
            r_rxCnt   <= HALF_BIT;
          end
        end
        RX_START: begin
          if (r_rxCnt != '0) begin
            r_rxCnt <= r_rxCnt - 1'b1;
          end else if (!r_rxSync) begin
            r_rxState <= RX_DATA;
            r_rxCnt   <= FULL_BIT;
            r_rxBit   <= '0;
          end else begin
            r_rxState <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (r_rxCnt != '0) begin
            r_rxCnt <= r_rxCnt - 1'b1;
          end else begin
            r_rxShift <= {r_rxSync, r_rxShift[7:1]};
            r_rxCnt   <= FULL_BIT;
            r_rxBit   <= r_rxBit + 3'd1;
            if (r_rxBit == 3'd7) r_rxState <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (r_rxCnt != '0) begin
            r_rxCnt <= r_rxCnt - 1'b1;
          end else begin
            if (r_rxSync) begin
              r_byteValid <= 1'b1;
              r_rxByte    <= r_rxShift;
            end else begin
              r_rxErr     <= 1'b1;
              o_frame_err <= 1'b1;
            end
            r_rxState <= RX_IDLE;
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  // Protocol: a framing error anywhere inside a frame abandons it and waits for a fresh sync byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pState     <= P_SYNC;
      r_cntLo      <= '0;
      r_count      <= '0;
      r_index      <= '0;
      r_lane       <= '0;
      r_word       <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= BASE_ADDR;
      o_imem_wdata <= '0;
      o_core_hold  <= 1'b1;
      o_load_done  <= 1'b0;
    end else begin
      o_imem_we <= 1'b0;
      case (r_pState)
        P_SYNC: begin
          if (r_byteValid && r_rxByte == SYNC_BYTE) r_pState <= P_CNT0;
        end
        P_CNT0: begin
          if (r_rxErr) begin
            r_pState <= P_SYNC;
          end else if (r_byteValid) begin
            r_cntLo  <= r_rxByte;
            r_pState <= P_CNT1;
          end
        end
        P_CNT1: begin
          if (r_rxErr) begin
            r_pState <= P_SYNC;
          end else if (r_byteValid) begin
            r_count  <= w_count;
            r_index  <= '0;
            r_lane   <= '0;
            r_pState <= (w_count == 16'd0) ? P_DONE : P_DATA;
          end
        end
        P_DATA: begin
          if (r_rxErr) begin
            r_pState <= P_SYNC;
          end else if (r_byteValid) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_word[7:0]   <= r_rxByte;
              2'd1: r_word[15:8]  <= r_rxByte;
              2'd2: r_word[23:16] <= r_rxByte;
              default: begin
                o_imem_we    <= 1'b1;
                o_imem_wdata <= {r_rxByte, r_word};
                o_imem_addr  <= BASE_ADDR + {14'b0, r_index, 2'b00};
                r_index      <= r_index + 16'd1;
                if (r_index == r_count - 16'd1) r_pState <= P_DONE;
              end
            endcase
          end
        end
        P_DONE: begin
          if (r_byteValid && r_rxByte == SYNC_BYTE) begin
            r_pState    <= P_CNT0;
            o_core_hold <= 1'b1;
            o_load_done <= 1'b0;
          end else begin
            o_core_hold <= 1'b0;
            o_load_done <= 1'b1;
          end
        end
        default: r_pState <= P_SYNC;
      endcase
    end
  end

`ifdef UART_BOOT_LOADER_ECHO_EN
  logic          r_txBusy, r_holdFull;
  logic [CW-1:0] r_txCnt;
  logic [3:0]    r_txBits;
  logic [8:0]    r_txShift;
  logic [7:0]    r_holdByte;
  logic          w_txFree;

  assign w_txFree = !r_txBusy || (r_txCnt == '0 && r_txBits == 4'd0);

  // Echo serializer; a byte arriving while both the shifter and the holding register are busy is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_uart_tx  <= 1'b1;
      r_txBusy   <= 1'b0;
      r_txCnt    <= '0;
      r_txBits   <= '0;
      r_txShift  <= '0;
      r_holdFull <= 1'b0;
      r_holdByte <= '0;
    end else if (w_txFree && r_holdFull) begin
      o_uart_tx  <= 1'b0;
      r_txShift  <= {1'b1, r_holdByte};
      r_txCnt    <= FULL_BIT;
      r_txBits   <= 4'd9;
      r_txBusy   <= 1'b1;
      r_holdFull <= r_byteValid;
      if (r_byteValid) r_holdByte <= r_rxByte;
    end else if (w_txFree && r_byteValid) begin
      o_uart_tx <= 1'b0;
      r_txShift <= {1'b1, r_rxByte};
      r_txCnt   <= FULL_BIT;
      r_txBits  <= 4'd9;
      r_txBusy  <= 1'b1;
    end else begin
      if (r_byteValid && !r_holdFull) begin
        r_holdFull <= 1'b1;
        r_holdByte <= r_rxByte;
      end
      if (w_txFree) begin
        r_txBusy  <= 1'b0;
        o_uart_tx <= 1'b1;
      end else if (r_txCnt != '0) begin
        r_txCnt <= r_txCnt - 1'b1;
      end else begin
        o_uart_tx <= r_txShift[0];
        r_txShift <= {1'b1, r_txShift[8:1]};
        r_txBits  <= r_txBits - 4'd1;
        r_txCnt   <= FULL_BIT;
      end
    end
  end
`else
  assign o_uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table-driven image vectors, hand-written corner
// sequences and randomized images compared against expected write lists built from the frame format.
module tb_uart_boot_loader;

  localparam int          CPB  = 8;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uartRx = 1'b1;
  logic        uartTx, imemWe, coreHold, loadDone, frameErr;
  logic [31:0] imemAddr, imemWdata;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_reset(reset), .i_uart_rx(uartRx), .o_uart_tx(uartTx),
    .o_imem_we(imemWe), .o_imem_addr(imemAddr), .o_imem_wdata(imemWdata),
    .o_core_hold(coreHold), .o_load_done(loadDone), .o_frame_err(frameErr)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail = 0;

  int          cyc = 0;
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  int          weCycQ[$];
  int          doneCycQ[$];
  int          doubleWe = 0;
  int          holdAtDoneRise = 0;
  int          txLow = 0;
  logic        prevWe = 1'b0;
  logic        prevDone = 1'b0;

  // Passive monitor sampling on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (imemWe) begin
      wrAddrQ.push_back(imemAddr);
      wrDataQ.push_back(imemWdata);
      weCycQ.push_back(cyc);
    end
    if (imemWe && prevWe) doubleWe++;
    if (loadDone && !prevDone) begin
      doneCycQ.push_back(cyc);
      if (coreHold) holdAtDoneRise++;
    end
    if (!uartTx) txLow++;
    prevWe = imemWe;
    prevDone = loadDone;
  end

  typedef struct {
    bit           doReset;
    int           n;
    logic [127:0] stream;
    int           badIdx;
    int           nWr;
    logic [127:0] words;
    logic         expDone;
    logic         expHold;
    logic         expErr;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    uartRx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit goodStop);
    uartRx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uartRx = goodStop;
    repeat (CPB) @(negedge clk);
    uartRx = 1'b1;
    repeat (goodStop ? 2 : 2 * CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input int v);
    if (vecs[v].doReset) applyReset();
    for (int j = 0; j < vecs[v].n; j++)
      sendByte(vecs[v].stream[8 * (vecs[v].n - 1 - j) +: 8], j != vecs[v].badIdx);
    repeat (4) @(negedge clk);
  endtask

  // Compares the writes captured since wrStart against the image words at BASE + 4*i.
  task automatic checkWrites(input string tag, input int wrStart, input int nExp, input logic [127:0] words);
    int obs;
    obs = wrAddrQ.size() - wrStart;
    checkOutput({tag, " write count"}, 32'(obs), 32'(nExp));
    for (int i = 0; i < nExp && i < obs; i++) begin
      checkOutput($sformatf("%s addr %0d", tag, i), wrAddrQ[wrStart + i], BASE + 32'(4 * i));
      checkOutput($sformatf("%s data %0d", tag, i), wrDataQ[wrStart + i], words[32 * i +: 32]);
    end
  endtask

  task automatic checkStatus(input string tag, input logic done, input logic hold, input logic err);
    checkOutput({tag, " load_done"}, 32'(loadDone), 32'(done));
    checkOutput({tag, " core_hold"}, 32'(coreHold), 32'(hold));
    checkOutput({tag, " frame_err"}, 32'(frameErr), 32'(err));
  endtask

  initial begin
    int          wrStart;
    int          doneStart;
    int          nJunk;
    int          cnt;
    logic [127:0] rw;
    logic [7:0]  jb;

    // Streams are written first byte leftmost; word lists are written word 0 rightmost.
    vecs[0] = '{1'b1, 11, 128'hA5_02_00_13_00_00_00_B3_00_50_00, -1, 2,
                {64'h0, 32'h005000B3, 32'h00000013}, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5, 128'h11_22_A5_00_00, -1, 0, 128'h0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5, 128'hA5_01_00_EF_3C, 4, 0, 128'h0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 7, 128'hA5_01_00_EF_BE_AD_DE, -1, 1,
                {96'h0, 32'hDEADBEEF}, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 11, 128'hA5_02_00_44_33_22_11_88_77_66_55, -1, 2,
                {64'h0, 32'h55667788, 32'h11223344}, 1'b1, 1'b0, 1'b1};

    applyReset();
    @(negedge clk);
    checkOutput("reset uart_tx", 32'(uartTx), 32'd1);
    checkOutput("reset imem_we", 32'(imemWe), 32'd0);
    checkOutput("reset imem_addr", imemAddr, BASE);
    checkOutput("reset imem_wdata", imemWdata, 32'h0);
    checkStatus("reset", 1'b0, 1'b1, 1'b0);

    for (int v = 0; v < 5; v++) begin
      wrStart = wrAddrQ.size();
      doneStart = doneCycQ.size();
      applyStimulus(v);
      checkWrites($sformatf("vec%0d", v), wrStart, vecs[v].nWr, vecs[v].words);
      checkStatus($sformatf("vec%0d", v), vecs[v].expDone, vecs[v].expHold, vecs[v].expErr);
      if (vecs[v].nWr > 0 && vecs[v].expDone) begin
        if (doneCycQ.size() > doneStart && weCycQ.size() > wrStart)
          checkOutput($sformatf("vec%0d done after last write", v),
                      32'(doneCycQ[$] - weCycQ[$]), 32'd1);
        else
          checkOutput($sformatf("vec%0d done rise seen", v), 32'd0, 32'd1);
      end
    end

    // One-cycle low glitch while idle must not produce a byte or disturb the loader.
    applyReset();
    wrStart = wrAddrQ.size();
    uartRx = 1'b0;
    @(negedge clk);
    uartRx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checkWrites("glitch", wrStart, 0, 128'h0);
    checkStatus("glitch", 1'b0, 1'b1, 1'b0);
    sendByte(8'hA5, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checkStatus("glitch then empty image", 1'b1, 1'b0, 1'b0);

    // A sync byte after a completed load re-arms the hold, and the next image restarts at BASE.
    sendByte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    checkStatus("reload sync", 1'b0, 1'b1, 1'b0);
    wrStart = wrAddrQ.size();
    sendByte(8'h01, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h78, 1'b1);
    sendByte(8'h56, 1'b1);
    sendByte(8'h34, 1'b1);
    sendByte(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    checkWrites("reload", wrStart, 1, {96'h0, 32'h12345678});
    checkStatus("reload", 1'b1, 1'b0, 1'b0);

`ifdef UART_BOOT_LOADER_ECHO_EN
    applyReset();
    fork
      sendByte(8'hA5, 1'b1);
      begin
        int t;
        logic [9:0] expFrame;
        t = 0;
        expFrame = {1'b1, 8'hA5, 1'b0};
        while (uartTx !== 1'b0 && t < 20 * CPB) begin
          @(negedge clk);
          t++;
        end
        if (t >= 20 * CPB) begin
          checkOutput("echo start bit seen", 32'd0, 32'd1);
        end else begin
          repeat (CPB / 2) @(negedge clk);
          for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("echo bit %0d", k), 32'(uartTx), 32'(expFrame[k]));
            repeat (CPB) @(negedge clk);
          end
        end
      end
    join
`endif

    // Random images: junk prefix, random word count, words expected at BASE + 4*i (wrapping).
    for (int r = 0; r < 4; r++) begin
      applyReset();
      wrStart = wrAddrQ.size();
      nJunk = $urandom_range(0, 2);
      cnt = $urandom_range(1, 4);
      rw = '0;
      for (int i = 0; i < nJunk; i++) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h5A;
        sendByte(jb, 1'b1);
      end
      sendByte(8'hA5, 1'b1);
      sendByte(8'(cnt), 1'b1);
      sendByte(8'h00, 1'b1);
      for (int i = 0; i < cnt; i++) begin
        rw[32 * i +: 32] = $urandom;
        for (int k = 0; k < 4; k++) sendByte(rw[32 * i + 8 * k +: 8], 1'b1);
      end
      repeat (4) @(negedge clk);
      checkWrites($sformatf("rand%0d", r), wrStart, cnt, rw);
      checkStatus($sformatf("rand%0d", r), 1'b1, 1'b0, 1'b0);
    end

    checkOutput("single-cycle imem_we", 32'(doubleWe), 32'd0);
    checkOutput("core_hold low at done rise", 32'(holdAtDoneRise), 32'd0);
`ifndef UART_BOOT_LOADER_ECHO_EN
    checkOutput("uart_tx idle without echo", 32'(txLow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
